// File: rtl/generador_percusion.sv
// generador_percusion: four-voice decaying square-wave drum generator with saturating mixer
module generador_percusion #(
  parameter int DIV      = 1024,
  parameter int AMP_MAX  = 16383,
  parameter int DECAY_SH = 9,
  parameter int HALF_P0  = 20,
  parameter int HALF_P1  = 30,
  parameter int HALF_P2  = 45,
  parameter int HALF_P3  = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3:0]         hit,
  output logic signed [15:0] sample,
  output logic               sample_valid,
  output logic [3:0]         voice_active
);
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [14:0] AMP_INIT = 15'(AMP_MAX);
  localparam logic [7:0] PCNT_LAST [4] = '{8'(HALF_P0 - 1), 8'(HALF_P1 - 1), 8'(HALF_P2 - 1), 8'(HALF_P3 - 1)};
  logic [CW-1:0] cnt_q;
  logic tick, tick_q, valid_q;
  logic [3:0] hit_q, pend_q, pend_d, apply;
  logic [14:0] amp_q [4];
  logic [14:0] amp_d [4];
  logic [7:0] pcnt_q [4];
  logic [7:0] pcnt_d [4];
  logic [3:0] phase_q, phase_d, active_q, active_d;
  logic [14:0] rem;
  logic signed [17:0] mix;
  logic signed [15:0] mix_sat, sample_q;
  assign tick = cnt_q == CNT_LAST;
  assign mix_sat = (mix > 18'sd32767) ? 16'sh7FFF : (mix < -18'sd32768) ? 16'sh8000 : mix[15:0];
  assign sample = sample_q;
  assign sample_valid = valid_q;
  assign voice_active = active_q;
  // Per-voice envelope/phase next state and the unsaturated mix of the current voices
  always_comb begin
    apply = pend_q | (hit & ~hit_q);
    pend_d = tick ? '0 : apply;
    mix = '0;
    rem = '0;
    phase_d = phase_q;
    for (int i = 0; i < 4; i++) begin
      amp_d[i] = amp_q[i];
      pcnt_d[i] = pcnt_q[i];
      rem = amp_q[i] - (amp_q[i] >> DECAY_SH);
      if (tick && apply[i]) begin
        amp_d[i] = AMP_INIT;
        pcnt_d[i] = '0;
        phase_d[i] = 1'b1;
      end else if (tick && amp_q[i] != '0) begin
        amp_d[i] = (rem != '0) ? rem - 15'd1 : '0;
        pcnt_d[i] = (pcnt_q[i] == PCNT_LAST[i]) ? '0 : pcnt_q[i] + 8'd1;
        phase_d[i] = phase_q[i] ^ (pcnt_q[i] == PCNT_LAST[i]);
      end
      active_d[i] = amp_d[i] != '0;
      mix = mix + (phase_q[i] ? $signed({3'b0, amp_q[i]}) : -$signed({3'b0, amp_q[i]}));
    end
  end
  // Divider, hit capture, voice state and the mix registered one cycle after each tick
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
      hit_q <= '0;
      pend_q <= '0;
      phase_q <= '0;
      active_q <= '0;
      sample_q <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        amp_q[i] <= '0;
        pcnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CW'(1);
      tick_q <= tick;
      hit_q <= hit;
      pend_q <= pend_d;
      phase_q <= phase_d;
      active_q <= active_d;
      for (int i = 0; i < 4; i++) begin
        amp_q[i] <= amp_d[i];
        pcnt_q[i] <= pcnt_d[i];
      end
      sample_q <= tick_q ? mix_sat : sample_q;
      valid_q <= tick_q;
    end
  end
endmodule
